// File: rtl/hex_rate_counter_if.sv
// Control and digit bundle between a rate-counter driver and the hex rate counter.
// Latency: wires only, no storage.
// Backpressure: none; enable is a level gate, and load is accepted on every clock.
interface hex_rate_counter_if;
    // Control inputs to the counter
    logic       enable;
    logic [1:0] rate_sel;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    // Registered outputs toward the hex decoder and any cascaded digit
    logic [3:0] digit;
    logic       tick;
    logic       wrap;

    modport master (
        output enable,
        output rate_sel,
        output up_down,
        output load,
        output load_value,
        input  digit,
        input  tick,
        input  wrap
    );

    modport slave (
        input  enable,
        input  rate_sel,
        input  up_down,
        input  load,
        input  load_value,
        output digit,
        output tick,
        output wrap
    );
endinterface

// File: rtl/hex_rate_counter.sv
// Hex digit (0-F) that steps up or down at a selectable rate derived from the board clock.
// Latency: first tick P edges after reset release or a load; all outputs are registered.
// Backpressure: none; enable freezes counting, and load wins even while counting is disabled.
module hex_rate_counter #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int DIV_W         = 28
) (
    input  logic                 clock,
    input  logic                 resetn,
    hex_rate_counter_if.slave    bus
);

    // Reload value (period minus one) for each rate selection.
    // A down-counter that reloads at zero therefore spans exactly P edges.
    function automatic logic [DIV_W-1:0] period_m1(input logic [1:0] sel);
        logic [DIV_W-1:0] r;
        r = '0;
        case (sel)
            2'b00:   r = '0;
            2'b01:   r = DIV_W'(TICKS_PER_SEC - 1);
            2'b10:   r = DIV_W'(2 * TICKS_PER_SEC - 1);
            default: r = DIV_W'(4 * TICKS_PER_SEC - 1);
        endcase
        return r;
    endfunction

    logic [DIV_W-1:0] divider;
    logic [1:0]       prev_sel;
    logic [3:0]       digit_q;
    logic             tick_q;
    logic             wrap_q;
    logic [DIV_W-1:0] reload;
    logic             sel_changed;
    logic [3:0]       digit_next;
    logic             wrap_next;

    // Reload value and next-digit arithmetic for the current inputs
    always_comb begin
        reload      = period_m1(bus.rate_sel);
        sel_changed = (bus.rate_sel != prev_sel);
        if (bus.up_down) begin
            digit_next = digit_q + 4'd1;
            wrap_next  = (digit_q == 4'hF);
        end else begin
            digit_next = digit_q - 4'd1;
            wrap_next  = (digit_q == 4'h0);
        end
    end

    // Divider, digit and pulse outputs. Priority: load, rate change, enable gate, count.
    // The remembered rate tracks rate_sel on every edge, so a load that coincides
    // with a rate change already reloads with the new period and does not trigger
    // a second restart on the following edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            divider  <= period_m1(bus.rate_sel);
            prev_sel <= bus.rate_sel;
            digit_q  <= 4'h0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            prev_sel <= bus.rate_sel;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            if (bus.load) begin
                digit_q <= bus.load_value;
                divider <= reload;
            end else if (sel_changed) begin
                divider <= reload;
            end else if (bus.enable) begin
                if (divider != '0) begin
                    divider <= divider - DIV_W'(1);
                end else begin
                    divider <= reload;
                    digit_q <= digit_next;
                    tick_q  <= 1'b1;
                    wrap_q  <= wrap_next;
                end
            end
        end
    end

    assign bus.digit = digit_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed bench for hex_rate_counter with a small period so every rate is quick to exercise.
// Latency: stimulus changes 1 time unit after each rising edge; outputs checked on falling edges.
// Backpressure: none.
module tb_hex_rate_counter;

    localparam int TPS = 4;

    logic clock;
    logic resetn;
    int   errors;
    int   checks;
    bit   cmp_on;

    hex_rate_counter_if bus ();

    hex_rate_counter #(
        .TICKS_PER_SEC(TPS),
        .DIV_W        (8)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural reference: counts edges elapsed in the current period
    // and applies the counter rules with plain integer arithmetic.
    int         m_elapsed;
    int         m_digit;
    bit         m_tick;
    bit         m_wrap;
    logic [1:0] m_sel;

    function automatic int period_of(input logic [1:0] sel);
        return (sel == 2'd0) ? 1 : (sel == 2'd1) ? TPS : (sel == 2'd2) ? 2 * TPS : 4 * TPS;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_elapsed = 0;
            m_digit   = 0;
            m_tick    = 0;
            m_wrap    = 0;
            m_sel     = bus.rate_sel;
        end else begin
            m_tick = 0;
            m_wrap = 0;
            if (bus.load) begin
                m_digit   = int'(bus.load_value);
                m_elapsed = 0;
            end else if (bus.rate_sel != m_sel) begin
                m_elapsed = 0;
            end else if (bus.enable) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == period_of(bus.rate_sel)) begin
                    m_elapsed = 0;
                    m_tick    = 1;
                    if (bus.up_down) begin
                        m_wrap  = (m_digit == 15);
                        m_digit = (m_digit + 1) % 16;
                    end else begin
                        m_wrap  = (m_digit == 0);
                        m_digit = (m_digit + 15) % 16;
                    end
                end
            end
            m_sel = bus.rate_sel;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the reference on every falling edge
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("model_digit", int'(bus.digit), m_digit);
            chk("model_tick",  int'(bus.tick),  int'(m_tick));
            chk("model_wrap",  int'(bus.wrap),  int'(m_wrap));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        cmp_on         = 1'b0;
        resetn         = 1'b0;
        bus.enable     = 1'b1;
        bus.rate_sel   = 2'b01;
        bus.up_down    = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = 4'h0;
        #2;
        cmp_on = 1'b1;

        // Reset, then count up at the 1 Hz setting
        repeat (3) step();
        chk("reset_digit", int'(bus.digit), 0);
        chk("reset_tick",  int'(bus.tick),  0);
        resetn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("up_tick_pattern", int'(bus.tick), (i % 4 == 0) ? 1 : 0);
            if (i == 4) chk("up_digit_after_4", int'(bus.digit), 1);
            if (i == 8) chk("up_digit_after_8", int'(bus.digit), 2);
        end

        // Wrap upward at the every-clock rate
        bus.load = 1'b1; bus.load_value = 4'hE; bus.rate_sel = 2'b00; bus.up_down = 1'b1;
        step();
        chk("wrapup_load", int'(bus.digit), 14);
        chk("wrapup_load_tick", int'(bus.tick), 0);
        bus.load = 1'b0;
        step(); chk("wrapup_F", int'(bus.digit), 15); chk("wrapup_F_wrap", int'(bus.wrap), 0);
        step(); chk("wrapup_0", int'(bus.digit), 0);  chk("wrapup_0_wrap", int'(bus.wrap), 1);
        step(); chk("wrapup_1", int'(bus.digit), 1);  chk("wrapup_1_wrap", int'(bus.wrap), 0);

        // Wrap downward
        bus.load = 1'b1; bus.load_value = 4'h1; bus.up_down = 1'b0;
        step(); chk("down_load", int'(bus.digit), 1);
        bus.load = 1'b0;
        step(); chk("down_0", int'(bus.digit), 0);  chk("down_0_wrap", int'(bus.wrap), 0);
        step(); chk("down_F", int'(bus.digit), 15); chk("down_F_wrap", int'(bus.wrap), 1);
        step(); chk("down_E", int'(bus.digit), 14); chk("down_E_wrap", int'(bus.wrap), 0);
        chk("down_E_tick", int'(bus.tick), 1);

        // Rate change part way through a 0.25 Hz period
        bus.rate_sel = 2'b11;
        step(); chk("rate11_switch_tick", int'(bus.tick), 0);
        for (int i = 0; i < 5; i++) begin
            step(); chk("rate11_no_tick", int'(bus.tick), 0);
        end
        bus.rate_sel = 2'b01;
        step();
        chk("rate01_switch_tick", int'(bus.tick), 0);
        chk("rate01_switch_digit", int'(bus.digit), 14);
        for (int i = 1; i <= 4; i++) begin
            step(); chk("rate01_tick_pos", int'(bus.tick), (i == 4) ? 1 : 0);
        end
        chk("rate01_digit", int'(bus.digit), 13);

        // Enable low freezes everything; load still wins
        bus.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("frozen_digit", int'(bus.digit), 13);
            chk("frozen_tick",  int'(bus.tick),  0);
        end
        bus.load = 1'b1; bus.load_value = 4'h9;
        step();
        chk("load_while_disabled", int'(bus.digit), 9);
        chk("load_while_disabled_tick", int'(bus.tick), 0);
        bus.load = 1'b0;

        // Asynchronous reset part way through a period
        bus.enable = 1'b1; bus.up_down = 1'b1;
        bus.load = 1'b1; bus.load_value = 4'h7;
        step(); chk("pre_reset_digit", int'(bus.digit), 7);
        bus.load = 1'b0;
        step(); step();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_digit", int'(bus.digit), 0);
        chk("async_reset_tick",  int'(bus.tick),  0);
        chk("async_reset_wrap",  int'(bus.wrap),  0);
        #2;
        resetn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("resume_tick", int'(bus.tick), (i == 4) ? 1 : 0);
            chk("resume_digit", int'(bus.digit), (i == 4) ? 1 : 0);
        end

        step();
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
